// File: rtl/keypad_matrix_scanner.sv
// Keypad matrix scanner: one-cold column drive, synchronized row readback, press/release debounce.
// Latency: rows 2 cycles through the synchronizer; key_valid DEBOUNCE_CYCLES cycles after the sample cycle.
// Backpressure: none; key_valid is a one-cycle strobe and the consumer must take it when it is high.
module keypad_matrix_scanner #(
   parameter int NUM_COLS        = 4,
   parameter int NUM_ROWS        = 4,
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int CODE_W          = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_ROWS-1:0] row_in,
   output logic [NUM_COLS-1:0] col_drive,
   output logic [CODE_W-1:0]   key_code,
   output logic                key_valid,
   output logic                key_held
);

   localparam int COL_W   = $clog2(NUM_COLS);
   localparam int ROW_W   = $clog2(NUM_ROWS);
   localparam int CNT_W   = $clog2(NUM_ROWS + 1);
   localparam int DWELL_W = $clog2(SCAN_DIV);
   localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES);

   localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(NUM_COLS - 1);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
   // The sample cycle already counts as the first stable observation, so the
   // press is accepted one count early and the registered outputs land exactly
   // DEBOUNCE_CYCLES cycles after the sample cycle.
   localparam logic [DEB_W-1:0]   PRESS_LAST = DEB_W'(DEBOUNCE_CYCLES - 2);
   localparam logic [DEB_W-1:0]   REL_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

   logic [NUM_ROWS-1:0] sync_q, rows_s_q;
   state_t              state_q, state_d;
   logic [COL_W-1:0]    col_q, col_d, col_next;
   logic [DWELL_W-1:0]  dwell_q, dwell_d;
   logic [DEB_W-1:0]    deb_q, deb_d;
   logic [ROW_W-1:0]    row_cap_q, row_cap_d, low_idx;
   logic [NUM_ROWS-1:0] pat_q, pat_d;
   logic [CODE_W-1:0]   key_code_q, key_code_d;
   logic                key_valid_q, key_valid_d;
   logic                key_held_q, key_held_d;
   logic [CNT_W-1:0]    low_cnt;
   logic                one_low, all_high, match;

   // Two-flop synchronizer for the asynchronous, pulled-up row inputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q   <= '1;
         rows_s_q <= '1;
      end else begin
         sync_q   <= row_in;
         rows_s_q <= sync_q;
      end
   end

   // Count low rows and locate the (last) low one; only a single low row is usable.
   always_comb begin
      low_cnt = '0;
      low_idx = '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         if (!rows_s_q[i]) begin
            low_cnt = low_cnt + CNT_W'(1);
            low_idx = ROW_W'(i);
         end
      end
   end

   assign one_low  = (low_cnt == CNT_W'(1));
   assign all_high = &rows_s_q;
   assign match    = (rows_s_q == pat_q);
   assign col_next = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);

   // Scan / debounce / held state machine: next state, counters and key outputs.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      dwell_d     = dwell_q;
      deb_d       = deb_q;
      row_cap_d   = row_cap_q;
      pat_d       = pat_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      case (state_q)
         SCAN: begin
            if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               if (one_low) begin
                  state_d   = DEBOUNCE;
                  deb_d     = '0;
                  row_cap_d = low_idx;
                  pat_d     = rows_s_q;
               end else begin
                  col_d = col_next;
               end
            end else begin
               dwell_d = dwell_q + DWELL_W'(1);
            end
         end
         DEBOUNCE: begin
            if (!match) begin
               state_d = SCAN;
               col_d   = col_next;
               dwell_d = '0;
               deb_d   = '0;
            end else if (deb_q == PRESS_LAST) begin
               state_d     = PRESSED;
               deb_d       = '0;
               key_code_d  = CODE_W'(int'(row_cap_q) * NUM_COLS + int'(col_q));
               key_valid_d = 1'b1;
               key_held_d  = 1'b1;
            end else begin
               deb_d = deb_q + DEB_W'(1);
            end
         end
         PRESSED: begin
            if (!all_high) begin
               deb_d = '0;
            end else if (deb_q == REL_LAST) begin
               state_d    = SCAN;
               col_d      = col_next;
               dwell_d    = '0;
               deb_d      = '0;
               key_held_d = 1'b0;
            end else begin
               deb_d = deb_q + DEB_W'(1);
            end
         end
         default: state_d = SCAN;
      endcase
   end

   // State register; reset wins over every state including mid-debounce and mid-hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= SCAN;
         col_q       <= '0;
         dwell_q     <= '0;
         deb_q       <= '0;
         row_cap_q   <= '0;
         pat_q       <= '1;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         dwell_q     <= dwell_d;
         deb_q       <= deb_d;
         row_cap_q   <= row_cap_d;
         pat_q       <= pat_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   // One-cold column drive from the registered column index.
   always_comb begin
      col_drive = ~(NUM_COLS'(1) << col_q);
   end

   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: keypad model driven by col_drive, scoreboard of expected key strobes.
// Latency: expects key_valid exactly 8 cycles after the sample cycle with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
// Backpressure: none; every key_valid is popped and compared in the cycle it appears.
module tb_keypad_matrix_scanner;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] row_in;
   logic [3:0] col_drive;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [3:0] key_mask [4];   // key_mask[row] = columns pressed on that row
   logic [3:0] force_low;
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   logic       prev_vld = 1'b0;

   typedef struct {
      logic [3:0] code;
      int         cyc;
   } exp_t;
   exp_t sb_q[$];

   keypad_matrix_scanner #(
      .NUM_COLS(4), .NUM_ROWS(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8), .CODE_W(4)
   ) dut (
      .clock(clock), .reset(reset), .row_in(row_in), .col_drive(col_drive),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Passive keypad: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      row_in = '1;
      for (int r = 0; r < 4; r++)
         row_in[r] = ~(|(key_mask[r] & ~col_drive)) & ~force_low[r];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic tick_to(input int t);
      while (cyc < t) tick();
   endtask

   task automatic push_exp(input logic [3:0] code, input int at);
      exp_t e;
      e.code = code;
      e.cyc  = at;
      sb_q.push_back(e);
   endtask

   // Output monitor: every strobe must match the oldest expected press, in code and cycle.
   always @(negedge clock) begin
      exp_t e;
      if (key_valid) begin
         check("valid_single_cycle", {31'd0, prev_vld}, 32'd0);
         check("sb_pending", {31'd0, sb_q.size() > 0}, 32'd1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_key_code", {28'd0, key_code}, {28'd0, e.code});
            check("sb_valid_cycle", cyc, e.cyc);
         end
      end
      prev_vld = key_valid;
   end

   initial begin
      int         b, r0, m, m2;
      logic [3:0] exp_col;

      for (int r = 0; r < 4; r++) key_mask[r] = 4'b0000;
      force_low = 4'hF;
      reset     = 1'b1;

      // Reset held for three edges with all rows low.
      repeat (3) begin
         tick();
         check("rst_col", {28'd0, col_drive}, 32'he);
         check("rst_code", {28'd0, key_code}, 32'd0);
         check("rst_valid", {31'd0, key_valid}, 32'd0);
         check("rst_held", {31'd0, key_held}, 32'd0);
      end
      reset     = 1'b0;
      force_low = 4'h0;

      // Idle scan: each column low for exactly 4 cycles, then wrap.
      for (int i = 0; i < 32; i++) begin
         exp_col = 4'b0001 << ((i / 4) % 4);
         exp_col = ~exp_col;
         check("scan_col", {28'd0, col_drive}, {28'd0, exp_col});
         tick();
      end

      // Clean press of row 2 / col 1: sample at b+7, strobe at b+15, code 9.
      b = cyc;
      key_mask[2] = 4'b0010;
      push_exp(4'd9, b + 15);
      tick_to(b + 14);
      check("press_held_early", {31'd0, key_held}, 32'd0);
      tick_to(b + 15);
      check("press_held", {31'd0, key_held}, 32'd1);
      check("press_code", {28'd0, key_code}, 32'd9);
      tick_to(b + 18);
      check("press_col_frozen", {28'd0, col_drive}, 32'hd);
      check("press_held_hold", {31'd0, key_held}, 32'd1);

      // Release with a 2-cycle glitch; held drops after 8 clean high cycles.
      r0 = b + 20;
      tick_to(r0);
      key_mask[2] = 4'b0000;
      tick_to(r0 + 3);
      key_mask[2] = 4'b0010;
      tick_to(r0 + 5);
      key_mask[2] = 4'b0000;
      tick_to(r0 + 14);
      check("rel_held_glitch", {31'd0, key_held}, 32'd1);
      tick_to(r0 + 15);
      check("rel_held_drop", {31'd0, key_held}, 32'd0);
      check("rel_col_next", {28'd0, col_drive}, 32'hb);
      check("rel_code_kept", {28'd0, key_code}, 32'd9);

      // Bounce during debounce: abort to col 2, then accept the stable press next visit.
      b = r0 + 23;
      tick_to(b);
      key_mask[2] = 4'b0010;
      tick_to(b + 8);
      key_mask[2] = 4'b0000;
      tick_to(b + 10);
      check("bounce_col_frozen", {28'd0, col_drive}, 32'hd);
      tick_to(b + 11);
      check("bounce_resume_col2", {28'd0, col_drive}, 32'hb);
      check("bounce_no_held", {31'd0, key_held}, 32'd0);
      key_mask[2] = 4'b0010;
      tick_to(b + 14);
      key_mask[2] = 4'b0000;
      tick_to(b + 17);
      key_mask[2] = 4'b0010;
      push_exp(4'd9, b + 34);
      tick_to(b + 34);
      check("bounce_accept_held", {31'd0, key_held}, 32'd1);
      tick_to(b + 40);
      key_mask[2] = 4'b0000;
      tick_to(b + 50);
      check("bounce_release", {31'd0, key_held}, 32'd0);

      // Two rows low on col 0: never accepted, scanning continues.
      m = b + 58;
      tick_to(m);
      key_mask[0] = 4'b0001;
      key_mask[1] = 4'b0001;
      tick_to(m + 36);
      check("multi_col_scanning", {28'd0, col_drive}, 32'hd);
      check("multi_no_held", {31'd0, key_held}, 32'd0);
      tick_to(m + 40);
      key_mask[0] = 4'b0000;
      key_mask[1] = 4'b0000;

      // Press row 3 / col 2 (code 14), then reset while held.
      m2 = m + 48;
      tick_to(m2);
      key_mask[3] = 4'b0100;
      push_exp(4'd14, m2 + 19);
      tick_to(m2 + 19);
      check("hold2_code", {28'd0, key_code}, 32'd14);
      check("hold2_held", {31'd0, key_held}, 32'd1);
      tick_to(m2 + 22);
      reset       = 1'b1;
      key_mask[3] = 4'b0000;
      tick();
      check("midhold_rst_held", {31'd0, key_held}, 32'd0);
      check("midhold_rst_code", {28'd0, key_code}, 32'd0);
      check("midhold_rst_col", {28'd0, col_drive}, 32'he);
      check("midhold_rst_valid", {31'd0, key_valid}, 32'd0);
      reset = 1'b0;
      repeat (20) tick();

      check("sb_empty", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
